logs_seq: RTL and testbench
===========================

Name: logs_seq

Overview:
- Note sequencer that drives one logs_nco square-wave oscillator from a small writable pattern table.
- Each table entry holds a frequency word and a duration. The block steps through the entries and generates the NCO frequency, step strobe and clear signals, with a short silent gap between notes.
- Sits between the host/config interface (table writes, start/stop) and the NCO. It is the only source of the NCO's freq_in, step and reset.

Parameters:
- N, 5, NCO phase-accumulator width; frequency word is N-1 bits.
- DUR_W, 4, duration field width, in ticks.
- NOTES, 8, table depth, power of two; IDX_W = log2(NOTES).
- TICK_W, 4, one tick = 2^TICK_W clocks; must be >= 1.
- STEP_W, 1, NCO step strobe every 2^STEP_W clocks during a note; must be >= 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  begin playback from entry 0; ignored while busy.
- stop  in  1  abort playback; takes priority over start.
- loop_en  in  1  at end of pattern, restart at entry 0 instead of finishing.
- wr_en  in  1  table write strobe.
- wr_addr  in  IDX_W  table write address.
- wr_data  in  DUR_W+N-1  table entry {dur, freq}.
- nco_freq  out  N-1  frequency word to the NCO's freq_in.
- nco_step  out  1  step strobe to the NCO.
- nco_clr  out  1  active-high clear to the NCO's reset.
- busy  out  1  high in LOAD, PLAY and GAP.
- done  out  1  one-cycle pulse on natural pattern end.
- cur_idx  out  IDX_W  entry index being played.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, cur_idx=0, nco_freq=0, nco_step=0, nco_clr=1, busy=0, done=0, all table entries=0.
- Table write: entry[wr_addr] <= wr_data on clk while wr_en=1, accepted in any state.
- An entry is latched only in LOAD. If a write and a LOAD hit the same address in the same cycle, LOAD gets the old value.
- An entry with dur=0 is the end marker. An entry with freq=0 is a rest: nco_clr stays high for the full duration.

State machine:
- IDLE: start=1 and stop=0 -> LOAD, with cur_idx=0.
- LOAD (1 cycle): latch the entry.
  - dur!=0 -> PLAY; dur counter = dur; tick and step counters cleared.
  - dur=0, loop_en=1 and cur_idx!=0 -> LOAD at index 0.
  - dur=0 otherwise -> DONE. A marker at index 0 always ends playback, so there is no infinite empty loop.
- PLAY: lasts exactly dur*2^TICK_W cycles.
  - nco_freq = latched freq.
  - nco_clr = (freq==0).
  - nco_step = 1 on the cycle the STEP_W-bit counter is all-ones, i.e. first pulse on the 2^STEP_W-th PLAY cycle.
  - On the last cycle -> GAP.
- GAP: lasts 2^TICK_W cycles; nco_freq=0, nco_clr=1, nco_step=0.
  - cur_idx < NOTES-1 -> increment cur_idx, go to LOAD.
  - cur_idx = NOTES-1 and loop_en=1 -> cur_idx wraps to 0, go to LOAD.
  - cur_idx = NOTES-1 and loop_en=0 -> DONE.
- DONE (1 cycle): done=1, busy=0 -> IDLE. cur_idx holds its last value until the next start.
- Outside PLAY: nco_freq=0, nco_step=0, nco_clr=1.
- loop_en is sampled only at the decision points above.
- stop=1 in any state: next state is IDLE. busy=0 and nco_clr=1 the following cycle; no done pulse; cur_idx holds.
- start while busy is ignored. start in the DONE cycle is ignored.
- rst_n asserted mid-note returns the block to the reset values immediately, table included.

Decomposition:
- Shared package logs_pkg holds:
  - state enum localparams: IDLE, LOAD, PLAY, GAP, DONE;
  - entry field slice helpers (DUR field in MSBs, FREQ field in LSBs);
  - default widths.
- One natural sub-module: logs_seq_tick. It takes clk, rst_n and a clear input, and outputs tick (every 2^TICK_W cycles) and step (every 2^STEP_W cycles) pulses. It is cleared on LOAD->PLAY and PLAY->GAP.
- The FSM, table and dur counter stay in logs_seq.

Test Plan (common parameters N=5, DUR_W=4, TICK_W=2, STEP_W=1):
- Table {0:{2,3}, 1:{1,0}, 2:{0,0}}, pulse start at cycle 0:
  - LOAD at cycle 1.
  - PLAY cycles 2-9 with nco_freq=3 and nco_step high on cycles 3, 5, 7, 9.
  - GAP cycles 10-13, LOAD 14.
  - Rest PLAY 15-18 with nco_clr=1 throughout.
  - GAP 19-22, LOAD 23, done=1 at cycle 24, IDLE at cycle 25.
- Same table with loop_en=1: after the marker at idx 2, cur_idx=0 and entry 0 replays with identical timing; no done pulse.
- Table all-zero, start -> done pulse 2 cycles later for any loop_en; busy high exactly 1 cycle.
- All 8 entries {1,5}, loop_en=0 -> cur_idx 0..7 in order, done after GAP of entry 7. With loop_en=1, cur_idx wraps 7->0.
- stop in the middle of PLAY of entry 0 -> next cycle busy=0, nco_clr=1, nco_freq=0, no done. start with stop in the same cycle -> stays IDLE.
- Write entry 0 := {1,7} during PLAY of entry 0 -> current note keeps freq 3. rst_n low mid-PLAY -> all outputs at reset values immediately; a following start gives done at once because the table was cleared.

Source files
------------

// File: rtl/logs_pkg.sv
`timescale 1ns/1ps
// Shared state encoding, default widths and table-entry field helpers for the note sequencer.
package logs_pkg;

    localparam int unsigned N_DEF      = 5;
    localparam int unsigned DUR_W_DEF  = 4;
    localparam int unsigned NOTES_DEF  = 8;
    localparam int unsigned TICK_W_DEF = 4;
    localparam int unsigned STEP_W_DEF = 1;
    localparam int unsigned ENT_MAX_W  = 64;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PLAY = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Entry layout is {dur, freq}; callers zero-extend the entry and truncate the result.
    function automatic logic [ENT_MAX_W-1:0] entry_freq(input logic [ENT_MAX_W-1:0] ent,
                                                        input int unsigned freq_w);
        logic [ENT_MAX_W-1:0] mask;
        mask = (ENT_MAX_W'(1) << freq_w) - ENT_MAX_W'(1);
        return ent & mask;
    endfunction

    function automatic logic [ENT_MAX_W-1:0] entry_dur(input logic [ENT_MAX_W-1:0] ent,
                                                       input int unsigned freq_w);
        return ent >> freq_w;
    endfunction

endpackage

// File: rtl/logs_seq_tick.sv
`timescale 1ns/1ps
// Tick/step timebase: tick is high on every 2^TICK_W-th cycle after clr,
// step_c flags that the coming cycle is a 2^STEP_W-th cycle after clr.
module logs_seq_tick
    import logs_pkg::*;
#(
    parameter int unsigned TICK_W = TICK_W_DEF,
    parameter int unsigned STEP_W = STEP_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick,
    output logic step_c
);

    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_cnt_next;
    logic [STEP_W-1:0] step_cnt;
    logic [STEP_W-1:0] step_cnt_next;

    always_comb begin
        tick_cnt_next = clr ? '0 : tick_cnt + TICK_W'(1);
        step_cnt_next = clr ? '0 : step_cnt + STEP_W'(1);
        step_c        = &step_cnt_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            step_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick_cnt <= tick_cnt_next;
            step_cnt <= step_cnt_next;
            tick     <= &tick_cnt_next;
        end
    end

endmodule

// File: rtl/logs_seq.sv
`timescale 1ns/1ps
// Note sequencer: walks a writable {dur, freq} table and drives one logs_nco
// with frequency, step strobe and clear, inserting a silent gap after each note.
module logs_seq
    import logs_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned DUR_W  = DUR_W_DEF,
    parameter int unsigned NOTES  = NOTES_DEF,
    parameter int unsigned TICK_W = TICK_W_DEF,
    parameter int unsigned STEP_W = STEP_W_DEF,
    localparam int unsigned IDX_W = $clog2(NOTES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   loop_en,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_addr,
    input  logic [DUR_W+N-2:0]     wr_data,
    output logic [N-2:0]           nco_freq,
    output logic                   nco_step,
    output logic                   nco_clr,
    output logic                   busy,
    output logic                   done,
    output logic [IDX_W-1:0]       cur_idx
);

    localparam int unsigned FREQ_W = N - 1;
    localparam int unsigned ENT_W  = DUR_W + FREQ_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOTES - 1);

    state_t             state;
    state_t             state_next;
    logic [ENT_W-1:0]   table_q [NOTES];
    logic [ENT_W-1:0]   ent_c;
    logic [DUR_W-1:0]   ent_dur_c;
    logic [FREQ_W-1:0]  ent_freq_c;
    logic [DUR_W-1:0]   dur_cnt;
    logic [DUR_W-1:0]   dur_next;
    logic [FREQ_W-1:0]  freq_q;
    logic [FREQ_W-1:0]  freq_next;
    logic [IDX_W-1:0]   idx_next;
    logic               tick;
    logic               step_c;
    logic               tick_clr_c;
    logic               play_c;
    logic               busy_next;
    logic               done_next;
    logic [FREQ_W-1:0]  nco_freq_next;
    logic               nco_step_next;
    logic               nco_clr_next;

    logs_seq_tick #(
        .TICK_W (TICK_W),
        .STEP_W (STEP_W)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tick_clr_c),
        .tick   (tick),
        .step_c (step_c)
    );

    // Read before this cycle's write lands, so a colliding LOAD sees the old entry.
    always_comb begin
        ent_c      = table_q[cur_idx];
        ent_dur_c  = DUR_W'(entry_dur(ENT_MAX_W'(ent_c), FREQ_W));
        ent_freq_c = FREQ_W'(entry_freq(ENT_MAX_W'(ent_c), FREQ_W));
    end

    always_comb begin
        state_next = state;
        idx_next   = cur_idx;
        dur_next   = dur_cnt;
        freq_next  = freq_q;
        tick_clr_c = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    idx_next   = '0;
                end
            end
            LOAD: begin
                freq_next = ent_freq_c;
                if (ent_dur_c != '0) begin
                    state_next = PLAY;
                    dur_next   = ent_dur_c;
                    tick_clr_c = 1'b1;
                end else if (loop_en && (cur_idx != '0)) begin
                    state_next = LOAD;
                    idx_next   = '0;
                end else begin
                    state_next = DONE;
                end
            end
            PLAY: begin
                if (tick) begin
                    if (dur_cnt == DUR_W'(1)) begin
                        state_next = GAP;
                        tick_clr_c = 1'b1;
                    end else begin
                        dur_next = dur_cnt - DUR_W'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (cur_idx != LAST_IDX) begin
                        state_next = LOAD;
                        idx_next   = cur_idx + IDX_W'(1);
                    end else if (loop_en) begin
                        state_next = LOAD;
                        idx_next   = '0;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Abort wins over everything and leaves the index where it was.
        if (stop) begin
            state_next = IDLE;
            idx_next   = cur_idx;
        end

        play_c        = (state_next == PLAY);
        busy_next     = (state_next == LOAD) || play_c || (state_next == GAP);
        done_next     = (state_next == DONE);
        nco_freq_next = play_c ? freq_next : '0;
        nco_step_next = play_c && step_c;
        nco_clr_next  = !play_c || (freq_next == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_idx  <= '0;
            dur_cnt  <= '0;
            freq_q   <= '0;
            nco_freq <= '0;
            nco_step <= 1'b0;
            nco_clr  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            cur_idx  <= idx_next;
            dur_cnt  <= dur_next;
            freq_q   <= freq_next;
            nco_freq <= nco_freq_next;
            nco_step <= nco_step_next;
            nco_clr  <= nco_clr_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NOTES; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en) begin
            table_q[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_logs_seq.sv
`timescale 1ns/1ps
// Directed bench for logs_seq at N=5, DUR_W=4, NOTES=8, TICK_W=2, STEP_W=1.
module tb_logs_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] nco_freq;
    logic       nco_step;
    logic       nco_clr;
    logic       busy;
    logic       done;
    logic [2:0] cur_idx;

    int n_cmp;
    int n_err;
    int cyc;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [3:0] freq;
        logic       step;
        logic       clr;
        logic [2:0] idx;
    } obs_t;

    logs_seq #(
        .N      (5),
        .DUR_W  (4),
        .NOTES  (8),
        .TICK_W (2),
        .STEP_W (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .nco_freq (nco_freq),
        .nco_step (nco_step),
        .nco_clr  (nco_clr),
        .busy     (busy),
        .done     (done),
        .cur_idx  (cur_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit at cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t mk(input logic b, input logic d, input logic [3:0] f,
                                input logic s, input logic c, input logic [2:0] i);
        obs_t o;
        o.busy = b;
        o.done = d;
        o.freq = f;
        o.step = s;
        o.clr  = c;
        o.idx  = i;
        return o;
    endfunction

    // Timeline for table {0:{2,3}, 1:{1,0}, 2:{0,0}} with start pulsed in cycle 0.
    function automatic obs_t tl(input int c);
        logic note0;
        logic stp;
        logic [2:0] idx;
        note0 = (c >= 2) && (c <= 9);
        stp   = (c == 3) || (c == 5) || (c == 7) || (c == 9) || (c == 16) || (c == 18);
        idx   = (c <= 13) ? 3'd0 : ((c <= 22) ? 3'd1 : 3'd2);
        return mk(c <= 23, c == 24, note0 ? 4'd3 : 4'd0, stp, !note0, idx);
    endfunction

    // Timeline for all eight entries {1,5}: 9 cycles per entry (LOAD, 4 PLAY, 4 GAP).
    function automatic obs_t t4(input int c);
        int  k;
        int  off;
        logic pl;
        if (c == 73) return mk(1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 3'd7);
        if (c >= 74) return mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd7);
        k   = (c - 1) / 9;
        off = (c - 1) % 9;
        pl  = (off >= 1) && (off <= 4);
        return mk(1'b1, 1'b0, pl ? 4'd5 : 4'd0, (off == 2) || (off == 4), !pl, 3'(k));
    endfunction

    task automatic chk_obs(input string tag, input obs_t exp);
        obs_t o;
        o = mk(busy, done, nco_freq, nco_step, nco_clr, cur_idx);
        n_cmp++;
        assert (o === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d: observed busy=%b done=%b freq=%0d step=%b clr=%b idx=%0d, expected busy=%b done=%b freq=%0d step=%b clr=%b idx=%0d",
                   tag, cyc, o.busy, o.done, o.freq, o.step, o.clr, o.idx,
                   exp.busy, exp.done, exp.freq, exp.step, exp.clr, exp.idx);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) next();
    endtask

    task automatic go();
        cyc   = 0;
        start = 1'b1;
        next();
        start = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        next();
        wr_en   = 1'b0;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        cyc     = 0;
        rst_n   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 3'd0;
        wr_data = 8'd0;

        #1 rst_n = 1'b0;
        #1 chk_obs("reset_async", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_obs("reset_state", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd0));
        next();
        chk_obs("idle_hold", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd0));

        wr(3'd0, 8'h23);
        wr(3'd1, 8'h10);
        wr(3'd2, 8'h00);
        chk_obs("idle_after_writes", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd0));

        // Single pass through note, rest and end marker.
        go();
        for (int c = 1; c <= 25; c++) begin
            run_to(c);
            chk_obs("play_once", tl(c));
        end

        // Looping: marker at idx 2 restarts at entry 0 with identical timing.
        loop_en = 1'b1;
        go();
        for (int c = 1; c <= 33; c++) begin
            run_to(c);
            chk_obs("loop", (c <= 23) ? tl(c) : tl(c - 23));
        end
        stop = 1'b1;
        next();
        stop = 1'b0;
        loop_en = 1'b0;
        chk_obs("loop_stop", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd0));

        // Stop mid-PLAY, then start and stop together.
        go();
        run_to(5);
        chk_obs("pre_stop", tl(5));
        stop = 1'b1;
        next();
        stop = 1'b0;
        chk_obs("stop_play", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd0));
        for (int i = 0; i < 4; i++) begin
            next();
            chk_obs("stop_nodone", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd0));
        end
        start = 1'b1;
        stop  = 1'b1;
        next();
        start = 1'b0;
        stop  = 1'b0;
        chk_obs("start_stop", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd0));
        next();
        chk_obs("start_stop_hold", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd0));

        // Rewrite the playing entry, then reset mid-note.
        go();
        run_to(3);
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 8'h17;
        next();
        wr_en   = 1'b0;
        for (int c = 4; c <= 7; c++) begin
            run_to(c);
            chk_obs("wr_during_play", tl(c));
        end
        #2 rst_n = 1'b0;
        #1 chk_obs("reset_midplay", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk_obs("reset_release", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd0));

        // Cleared table: end marker at index 0, regardless of loop_en.
        for (int l = 0; l < 2; l++) begin
            loop_en = (l == 1);
            go();
            chk_obs("zero_load", mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 3'd0));
            next();
            chk_obs("zero_done", mk(1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 3'd0));
            next();
            chk_obs("zero_idle", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd0));
        end
        loop_en = 1'b0;

        // Full table walk, then with wrap 7 -> 0.
        for (int a = 0; a < 8; a++) wr(3'(a), 8'h15);
        go();
        for (int c = 1; c <= 74; c++) begin
            run_to(c);
            chk_obs("walk", t4(c));
        end
        loop_en = 1'b1;
        go();
        for (int c = 1; c <= 80; c++) begin
            run_to(c);
            chk_obs("walk_loop", (c <= 72) ? t4(c) : t4(c - 72));
        end
        stop = 1'b1;
        next();
        stop = 1'b0;
        loop_en = 1'b0;
        chk_obs("walk_stop", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
